trng_sampler: RTL and testbench

- Consumer end of the ring-oscillator entropy source; the only block that drives the oscillators' `RO_enable` inputs and reads their `random_bit` outputs.
- Runs in the system clock domain and performs these steps in order: synchronise the N asynchronous RO bits, XOR-combine them, sample at a programmable rate, apply von Neumann debiasing, pack the result into words.
- Delivers words over a valid/ready stream to the TRNG register interface.

---
 rtl/trng_sampler.sv | 167 ++++++++++++++++
 tb/tb_trng_sampler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_sampler.sv
// ---------------------------------------------------------------------------
// trng_sampler
// Samples a bank of free-running ring oscillators and turns their output
// into debiased random words.
// The processing order is: synchroniser, XOR combine, rate-divided sample
// strobe, von Neumann pair debiasing, and shift-register packing into words.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active high
//   enable_i     1 = produce words, 0 = return to IDLE
//   ro_enable_o  RO_enable for every oscillator (1 = held static)
//   ro_bits_i    asynchronous random_bit of each oscillator
//   rnd_data_o   output word
//   rnd_valid_o  rnd_data_o holds an unconsumed word
//   rnd_ready_i  consumer accepts the word this cycle
//   busy_o       FSM is not in IDLE
// ---------------------------------------------------------------------------
module trng_sampler #(
  parameter int N_RO          = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int SAMPLE_DIV    = 16,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  output logic                  ro_enable_o,
  input  logic [N_RO-1:0]       ro_bits_i,
  output logic [WORD_WIDTH-1:0] rnd_data_o,
  output logic                  rnd_valid_o,
  input  logic                  rnd_ready_i,
  output logic                  busy_o
);

  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
  localparam int CNT_W  = $clog2(WORD_WIDTH + 1);

  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_WIDTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;

  // Synchroniser chain: index 0 is the first stage, SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0][N_RO-1:0] r_sync;

  logic [1:0]            r_state;
  logic                  r_ro_enable;
  logic [WARM_W-1:0]     r_warm_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WORD_WIDTH-1:0] r_acc;
  logic                  r_pair;
  logic                  r_first;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic                  w_c;
  logic                  w_strobe;
  logic                  w_full;
  logic                  w_transfer;
  logic                  w_take;
  logic                  w_emit;
  logic                  w_go_idle;
  logic [CNT_W-1:0]      w_cnt_base;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_bits_i};
    end
  end

  assign w_c        = ^r_sync[SYNC_STAGES-1];
  assign w_strobe   = (r_state == S_COLLECT) && (r_div_cnt == DIV_LAST);
  assign w_full     = (r_bit_cnt == CNT_FULL);
  assign w_transfer = w_full && (!r_valid || rnd_ready_i);
  // A full accumulator that cannot hand off swallows the strobe untouched;
  // once the hand-off happens the same strobe starts the next word.
  assign w_take     = w_strobe && (!w_full || w_transfer);
  // Second sample of a pair: differing bits emit the first one (10->1, 01->0).
  assign w_emit     = w_take && r_pair && (r_first != w_c);
  assign w_go_idle  = (r_state != S_IDLE) && !enable_i;
  assign w_cnt_base = w_transfer ? '0 : r_bit_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ro_enable <= 1'b1;
      r_warm_cnt  <= '0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_acc       <= '0;
      r_pair      <= 1'b0;
      r_first     <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      // Output register is independent of enable_i: a finished word is
      // always delivered and held until the consumer takes it.
      if (w_transfer) begin
        r_data  <= r_acc;
        r_valid <= 1'b1;
      end else if (r_valid && rnd_ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_go_idle) begin
        r_state     <= S_IDLE;
        r_ro_enable <= 1'b1;
        r_warm_cnt  <= '0;
        r_div_cnt   <= '0;
        r_bit_cnt   <= '0;
        r_acc       <= '0;
        r_pair      <= 1'b0;
        r_first     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable_i) begin
              r_state     <= S_WARMUP;
              r_warm_cnt  <= WARM_LOAD;
              r_ro_enable <= 1'b0;
            end
          end
          S_WARMUP: begin
            if (r_warm_cnt == '0) begin
              r_state   <= S_COLLECT;
              r_div_cnt <= '0;
            end else begin
              r_warm_cnt <= r_warm_cnt - 1'b1;
            end
          end
          S_COLLECT: begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            r_bit_cnt <= w_cnt_base + CNT_W'(w_emit);
            if (w_take) begin
              r_pair <= ~r_pair;
            end
            if (w_take && !r_pair) begin
              r_first <= w_c;
            end
            if (w_emit) begin
              r_acc <= {r_acc[WORD_WIDTH-2:0], r_first};
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_ro_enable <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ro_enable_o = r_ro_enable;
  assign rnd_data_o  = r_data;
  assign rnd_valid_o = r_valid;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_trng_sampler.sv
// ---------------------------------------------------------------------------
// tb_trng_sampler
// Directed scenarios plus a randomized run for trng_sampler, checked against
// a cycle-level behavioural model (bit queue, integer counters).
// ---------------------------------------------------------------------------
module tb_trng_sampler;

  localparam int N_RO = 1;
  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int SD   = 1;
  localparam int WU   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            ready;
  logic [N_RO-1:0] ro;
  logic            ro_enable_o;
  logic [W-1:0]    rnd_data_o;
  logic            rnd_valid_o;
  logic            busy_o;

  always #5 clk = ~clk;

  trng_sampler #(
    .N_RO(N_RO), .WORD_WIDTH(W), .SYNC_STAGES(SS),
    .SAMPLE_DIV(SD), .WARMUP_CYCLES(WU)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .ro_enable_o(ro_enable_o),
    .ro_bits_i(ro), .rnd_data_o(rnd_data_o), .rnd_valid_o(rnd_valid_o),
    .rnd_ready_i(ready), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_mode;   // 0 idle, 1 warmup, 2 collect
  int           m_warm;
  int           m_div;
  bit           m_pair;
  bit           m_first;
  bit           m_bits[$];   // debiased bits of the word being built, oldest first
  bit           m_sync[$];   // delay line, oldest at index 0
  bit           m_valid;
  logic [W-1:0] m_data;

  function automatic void m_reset();
    m_mode = 0; m_warm = 0; m_div = 0; m_pair = 0; m_first = 0;
    m_bits.delete();
    m_sync.delete();
    for (int i = 0; i < SS; i++) m_sync.push_back(1'b0);
    m_valid = 0; m_data = '0;
  endfunction

  function automatic void m_idle();
    m_mode = 0; m_warm = 0; m_div = 0; m_pair = 0; m_first = 0;
    m_bits.delete();
  endfunction

  function automatic void m_step(bit r, bit e, bit rd, bit robit);
    bit c, xfer, strobe;
    if (r) begin
      m_reset();
      return;
    end
    c      = m_sync[0];
    xfer   = (m_bits.size() == W) && (!m_valid || rd);
    strobe = (m_mode == 2) && (m_div == SD - 1);
    if (xfer) begin
      for (int i = 0; i < W; i++) m_data[W-1-i] = m_bits[i];
      m_valid = 1;
      m_bits.delete();
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
    if (m_mode != 0 && !e) begin
      m_idle();
    end else if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_warm = WU - 1; end
    end else if (m_mode == 1) begin
      if (m_warm == 0) begin m_mode = 2; m_div = 0; end
      else m_warm--;
    end else begin
      if (strobe && m_bits.size() < W) begin
        if (!m_pair) begin
          m_first = c; m_pair = 1;
        end else begin
          m_pair = 0;
          if (m_first != c) m_bits.push_back(m_first);
        end
      end
      m_div = (m_div == SD - 1) ? 0 : m_div + 1;
    end
    void'(m_sync.pop_front());
    m_sync.push_back(robit);
  endfunction

  // ---------------- cycle driver ----------------
  int           cyc = 0;
  int           hs_cnt = 0;
  int           hs_cyc = 0;
  logic [W-1:0] hs_data = '0;
  bit           stim_q[$];

  task automatic tick();
    if (rnd_valid_o === 1'b1 && ready === 1'b1) begin
      hs_cnt++;
      hs_data = rnd_data_o;
      hs_cyc  = cyc;
      $display("[%0t] word 0x%h accepted", $time, rnd_data_o);
    end
    @(posedge clk);
    m_step(rst, en, ready, ^ro);
    cyc++;
    #1;
    chk("ro_enable", {31'd0, ro_enable_o}, {31'd0, m_mode == 0});
    chk("busy",      {31'd0, busy_o},      {31'd0, m_mode != 0});
    chk("valid",     {31'd0, rnd_valid_o}, {31'd0, m_valid});
    chk("data",      {24'd0, rnd_data_o},  {24'd0, m_data});
  endtask

  // Enable, then drive stim_q so its first bit lands on the first strobe.
  task automatic run_stream(input int tail, output int t0);
    en = 1'b1; ro = '0;
    tick();
    chk("enable ro_enable fell", {31'd0, ro_enable_o}, 32'd0);
    chk("enable busy",           {31'd0, busy_o},      32'd1);
    tick(); tick();
    t0 = cyc;
    foreach (stim_q[i]) begin
      ro = stim_q[i];
      tick();
    end
    ro = '0;
    for (int i = 0; i < tail; i++) tick();
  endtask

  task automatic go_idle();
    en = 1'b0;
    tick(); tick();
  endtask

  int t0, t2, t3;

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b1; ro = '0;
    m_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset ro_enable", {31'd0, ro_enable_o}, 32'd1);
    chk("reset busy",      {31'd0, busy_o},      32'd0);
    chk("reset valid",     {31'd0, rnd_valid_o}, 32'd0);
    chk("reset data",      {24'd0, rnd_data_o},  32'd0);

    // Scenarios 1+2: basic stream with ready held high
    stim_q = '{1,0, 0,1, 1,0, 1,0, 0,1, 0,1, 1,0, 0,1};
    hs_cnt = 0;
    run_stream(12, t0);
    chk("s2 word",  {24'd0, hs_data}, 32'h0000_00B2);
    chk("s2 count", hs_cnt, 1);
    t2 = hs_cyc - t0;
    go_idle();

    // Scenario 3: 00 and 11 pairs are discarded, word arrives 4 strobes later
    stim_q = '{1,0, 0,1, 0,0, 1,0, 1,0, 0,1, 1,1, 0,1, 1,0, 0,1};
    hs_cnt = 0;
    run_stream(12, t0);
    chk("s3 word",  {24'd0, hs_data}, 32'h0000_00B2);
    chk("s3 count", hs_cnt, 1);
    t3 = hs_cyc - t0;
    chk("s3 delay", t3, t2 + 4);
    go_idle();

    // Scenario 4: backpressure with all-10 pairs
    ready = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 20; i++) begin stim_q.push_back(1'b1); stim_q.push_back(1'b0); end
    hs_cnt = 0;
    run_stream(4, t0);
    chk("s4 held valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("s4 held data",  {24'd0, rnd_data_o},  32'h0000_00FF);
    chk("s4 no handshake", hs_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4 stable data", {24'd0, rnd_data_o}, 32'h0000_00FF);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("s4 refill valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("s4 refill data",  {24'd0, rnd_data_o},  32'h0000_00FF);
    chk("s4 first taken",  hs_cnt, 1);
    tick(); tick();
    ready = 1'b1;
    tick();
    chk("s4 drained valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("s4 second taken",  hs_cnt, 2);
    go_idle();

    // Scenario 5: drop enable with three bits accumulated
    stim_q = '{1,0, 0,1, 1,0};
    run_stream(2, t0);
    en = 1'b0;
    tick();
    chk("s5 ro_enable", {31'd0, ro_enable_o}, 32'd1);
    chk("s5 busy",      {31'd0, busy_o},      32'd0);
    tick();
    stim_q = '{1,0, 0,1, 1,0, 1,0, 0,1, 0,1, 1,0, 0,1};
    hs_cnt = 0;
    run_stream(12, t0);
    chk("s5 word",  {24'd0, hs_data}, 32'h0000_00B2);
    chk("s5 count", hs_cnt, 1);
    go_idle();

    // Scenario 6: reset with a pending word
    ready = 1'b0;
    run_stream(12, t0);
    chk("s6 pending", {31'd0, rnd_valid_o}, 32'd1);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    chk("s6 valid",     {31'd0, rnd_valid_o}, 32'd0);
    chk("s6 data",      {24'd0, rnd_data_o},  32'd0);
    chk("s6 ro_enable", {31'd0, ro_enable_o}, 32'd1);
    chk("s6 busy",      {31'd0, busy_o},      32'd0);

    // Randomized run against the model
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ro    = N_RO'($urandom);
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) en = ~en;
      rst   = ($urandom_range(999) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
